shiftreg_frame_loader: RTL and testbench

// - Serial configuration loader: shifts frames from SDI into a dynamic or a static shift register, selected by SELDYN/SELSTAT.
// - Adds frame-bit counting and auto-latch on completion.
// - Adds abort, overrun and select-conflict detection, and per-channel valid pulses.
// - Sits between the serial config port and the datapath. DYNLATCH/STATLATCH feed downstream logic.

---
 rtl/shiftreg_frame_loader.sv | 216 +++++++++++++++++++++
 tb/tb_shiftreg_frame_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_frame_loader.sv
// Serial configuration loader: shifts MSB-first frames from SDI into a dynamic
// or static shift register, latches complete frames and flags protocol errors.
// Optional feature macro SHIFTREG_PARITY_EN: each frame carries one trailing
// even-parity bit and a bad frame sets ERR_PAR instead of updating the latch.
module shiftreg_frame_loader #(
  parameter int unsigned       DYN_W     = 16,
  parameter int unsigned       STAT_W    = 88,
  parameter logic [DYN_W-1:0]  DYN_INIT  = 16'hABCD,
  parameter logic [STAT_W-1:0] STAT_INIT = 88'h123456789ABCDEF1234567,
  parameter int unsigned       CNT_W     = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SELDYN,
  input  logic              SELSTAT,
  input  logic              SDI,
  input  logic              CLR_ERR,
  output logic [DYN_W-1:0]  DYNLATCH,
  output logic [STAT_W-1:0] STATLATCH,
  output logic              DYN_VALID,
  output logic              STAT_VALID,
  output logic              BUSY,
  output logic              SDO,
  output logic              ERR_ABORT,
  output logic              ERR_OVR,
  output logic              ERR_SEL
`ifdef SHIFTREG_PARITY_EN
  ,
  output logic              ERR_PAR
`endif
);

`ifdef SHIFTREG_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  // Count value on entry to the final (completing) edge of each frame type
  localparam logic [CNT_W-1:0] DYN_LAST  = CNT_W'(DYN_W + PAR_BITS - 1);
  localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(STAT_W + PAR_BITS - 1);

  typedef enum logic [2:0] {IDLE, SH_DYN, SH_STAT, HOLD, CONFLICT} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [DYN_W-1:0]    dyn_sh, dyn_sh_next, dyn_lat_next;
  logic [STAT_W-1:0]   stat_sh, stat_sh_next, stat_lat_next;
  logic                dyn_upd, dyn_upd_next, stat_upd, stat_upd_next;
  logic                sdo_next;
  logic                abort_ev, ovr_ev, sel_ev;
  logic                err_abort_next, err_ovr_next, err_sel_next;
`ifdef SHIFTREG_PARITY_EN
  logic                par_ev, err_par_next;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, shifting, latching and error-event decode
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    dyn_sh_next   = DYN_INIT;
    stat_sh_next  = STAT_INIT;
    dyn_lat_next  = DYNLATCH;
    stat_lat_next = STATLATCH;
    dyn_upd_next  = 1'b0;
    stat_upd_next = 1'b0;
    sdo_next      = 1'b0;
    abort_ev      = 1'b0;
    ovr_ev        = 1'b0;
    sel_ev        = SELDYN & SELSTAT;
`ifdef SHIFTREG_PARITY_EN
    par_ev        = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (sel_ev) begin
          state_next = CONFLICT;
        end else if (SELDYN) begin
          dyn_sh_next = {dyn_sh[DYN_W-2:0], SDI};
          cnt_next    = CNT_W'(1);
          sdo_next    = SDI;
          state_next  = SH_DYN;
        end else if (SELSTAT) begin
          stat_sh_next = {stat_sh[STAT_W-2:0], SDI};
          cnt_next     = CNT_W'(1);
          sdo_next     = SDI;
          state_next   = SH_STAT;
        end
      end
      SH_DYN: begin
        if (SELDYN && !SELSTAT) begin
          sdo_next = SDI;
          cnt_next = cnt + CNT_W'(1);
          if (cnt == DYN_LAST) begin
`ifdef SHIFTREG_PARITY_EN
            if (^{dyn_sh, SDI} == 1'b0) begin
              dyn_lat_next = dyn_sh;
              dyn_upd_next = 1'b1;
            end else begin
              par_ev = 1'b1;
            end
`else
            dyn_lat_next = {dyn_sh[DYN_W-2:0], SDI};
            dyn_upd_next = 1'b1;
`endif
            state_next = HOLD;
          end else begin
            dyn_sh_next = {dyn_sh[DYN_W-2:0], SDI};
          end
        end else begin
          abort_ev   = 1'b1;
          cnt_next   = '0;
          state_next = sel_ev ? CONFLICT : IDLE;
        end
      end
      SH_STAT: begin
        if (SELSTAT && !SELDYN) begin
          sdo_next = SDI;
          cnt_next = cnt + CNT_W'(1);
          if (cnt == STAT_LAST) begin
`ifdef SHIFTREG_PARITY_EN
            if (^{stat_sh, SDI} == 1'b0) begin
              stat_lat_next = stat_sh;
              stat_upd_next = 1'b1;
            end else begin
              par_ev = 1'b1;
            end
`else
            stat_lat_next = {stat_sh[STAT_W-2:0], SDI};
            stat_upd_next = 1'b1;
`endif
            state_next = HOLD;
          end else begin
            stat_sh_next = {stat_sh[STAT_W-2:0], SDI};
          end
        end else begin
          abort_ev   = 1'b1;
          cnt_next   = '0;
          state_next = sel_ev ? CONFLICT : IDLE;
        end
      end
      HOLD: begin
        // A select still high after completion means the sender ran long
        if (SELDYN || SELSTAT) begin
          ovr_ev = 1'b1;
        end else begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      CONFLICT: begin
        cnt_next = '0;
        if (!SELDYN && !SELSTAT) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    // Sticky flags: a same-edge error event overrides the clear
    err_abort_next = (ERR_ABORT & ~CLR_ERR) | abort_ev;
    err_ovr_next   = (ERR_OVR & ~CLR_ERR) | ovr_ev;
    err_sel_next   = (ERR_SEL & ~CLR_ERR) | sel_ev;
`ifdef SHIFTREG_PARITY_EN
    err_par_next   = (ERR_PAR & ~CLR_ERR) | par_ev;
`endif
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= '0;
      dyn_sh     <= DYN_INIT;
      stat_sh    <= STAT_INIT;
      DYNLATCH   <= DYN_INIT;
      STATLATCH  <= STAT_INIT;
      dyn_upd    <= 1'b0;
      stat_upd   <= 1'b0;
      DYN_VALID  <= 1'b0;
      STAT_VALID <= 1'b0;
      BUSY       <= 1'b0;
      SDO        <= 1'b0;
      ERR_ABORT  <= 1'b0;
      ERR_OVR    <= 1'b0;
      ERR_SEL    <= 1'b0;
`ifdef SHIFTREG_PARITY_EN
      ERR_PAR    <= 1'b0;
`endif
    end else begin
      cnt        <= cnt_next;
      dyn_sh     <= dyn_sh_next;
      stat_sh    <= stat_sh_next;
      DYNLATCH   <= dyn_lat_next;
      STATLATCH  <= stat_lat_next;
      dyn_upd    <= dyn_upd_next;
      stat_upd   <= stat_upd_next;
      DYN_VALID  <= dyn_upd;
      STAT_VALID <= stat_upd;
      BUSY       <= (state_next != IDLE);
      SDO        <= sdo_next;
      ERR_ABORT  <= err_abort_next;
      ERR_OVR    <= err_ovr_next;
      ERR_SEL    <= err_sel_next;
`ifdef SHIFTREG_PARITY_EN
      ERR_PAR    <= err_par_next;
`endif
    end
  end

endmodule

// File: tb/tb_shiftreg_frame_loader.sv
// Directed self-checking bench for shiftreg_frame_loader (default 16/88-bit frames).
module tb_shiftreg_frame_loader;

  localparam logic [15:0] DYN_INIT_V  = 16'hABCD;
  localparam logic [87:0] STAT_INIT_V = 88'h123456789ABCDEF1234567;
  localparam logic [87:0] STAT_PAT    = {11{8'hA5}};
`ifdef SHIFTREG_PARITY_EN
  localparam int FRAME_EXTRA = 1;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N, SELDYN, SELSTAT, SDI, CLR_ERR;
  logic [15:0] DYNLATCH;
  logic [87:0] STATLATCH;
  logic        DYN_VALID, STAT_VALID, BUSY, SDO, ERR_ABORT, ERR_OVR, ERR_SEL;
`ifdef SHIFTREG_PARITY_EN
  logic        ERR_PAR;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  logic busy_all;

  shiftreg_frame_loader dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SELDYN     (SELDYN),
    .SELSTAT    (SELSTAT),
    .SDI        (SDI),
    .CLR_ERR    (CLR_ERR),
    .DYNLATCH   (DYNLATCH),
    .STATLATCH  (STATLATCH),
    .DYN_VALID  (DYN_VALID),
    .STAT_VALID (STAT_VALID),
    .BUSY       (BUSY),
    .SDO        (SDO),
    .ERR_ABORT  (ERR_ABORT),
    .ERR_OVR    (ERR_OVR),
    .ERR_SEL    (ERR_SEL)
`ifdef SHIFTREG_PARITY_EN
    ,
    .ERR_PAR    (ERR_PAR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, then sample 1 time unit after the rising edge
  task automatic drive(input logic sd, input logic ss, input logic b);
    SELDYN  = sd;
    SELSTAT = ss;
    SDI     = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_dyn_bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, d[15-i]);
  endtask

  task automatic send_dyn_frame(input logic [15:0] d);
    send_dyn_bits(d, 16);
`ifdef SHIFTREG_PARITY_EN
    drive(1'b1, 1'b0, ^d);
`endif
  endtask

  task automatic send_stat_frame(input logic [87:0] d);
    busy_all = 1'b1;
    for (int i = 0; i < 88; i++) begin
      drive(1'b0, 1'b1, d[87-i]);
      busy_all = busy_all & BUSY;
    end
`ifdef SHIFTREG_PARITY_EN
    drive(1'b0, 1'b1, ^d);
    busy_all = busy_all & BUSY;
`endif
  endtask

  initial begin
    RST_N = 1'b0; SELDYN = 1'b0; SELSTAT = 1'b0; SDI = 1'b0; CLR_ERR = 1'b0;
    #23;
    check("rst_dynlatch",  DYNLATCH,  DYN_INIT_V);
    check("rst_statlatch", STATLATCH, STAT_INIT_V);
    check("rst_busy",      BUSY,      1'b0);
    check("rst_valids",    {DYN_VALID, STAT_VALID, SDO}, 3'b000);
    check("rst_errs",      {ERR_ABORT, ERR_OVR, ERR_SEL}, 3'b000);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 1'b0);
    check("idle_busy", BUSY, 1'b0);

    // Dynamic frame 16'h1234
    drive(1'b1, 1'b0, 1'b0);
    check("dyn_first_busy", BUSY, 1'b1);
    send_dyn_bits(16'h1234 << 1, 3);
    check("dyn_sdo_bit4", SDO, 1'b1);
    send_dyn_bits(16'h1234 << 4, 12);
`ifdef SHIFTREG_PARITY_EN
    drive(1'b1, 1'b0, 1'b1);
`endif
    check("dyn_1234_latch",    DYNLATCH, 16'h1234);
    check("dyn_1234_valid_lo", DYN_VALID, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("dyn_1234_valid_hi", DYN_VALID, 1'b1);
    check("dyn_1234_busy",     BUSY, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("dyn_1234_valid_end", DYN_VALID, 1'b0);
    check("dyn_1234_stat",      STATLATCH, STAT_INIT_V);
    check("dyn_1234_errs",      {ERR_ABORT, ERR_OVR, ERR_SEL}, 3'b000);

    // Reset in the middle of a dynamic frame
    send_dyn_bits(16'hFFFF, 5);
    check("mid_sdo_pre", SDO, 1'b1);
    #2;
    RST_N  = 1'b0;
    SELDYN = 1'b0;
    #1;
    check("mid_rst_dynlatch", DYNLATCH, DYN_INIT_V);
    check("mid_rst_busy_sdo", {BUSY, SDO}, 2'b00);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Static frame of repeated A5
    send_stat_frame(STAT_PAT);
    check("stat_busy_all",  busy_all, 1'b1);
    check("stat_latch",     STATLATCH, STAT_PAT);
    check("stat_valid_lo",  STAT_VALID, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("stat_valid_hi",  STAT_VALID, 1'b1);
    check("stat_dyn_keep",  DYNLATCH, DYN_INIT_V);
    drive(1'b0, 1'b0, 1'b0);
    check("stat_valid_end", STAT_VALID, 1'b0);

    // Abort after 9 dynamic bits, then a clean 16'hBEEF frame
    send_dyn_bits(16'h5555, 8);
    check("abort_sdo8", SDO, 1'b1);
    send_dyn_bits(16'h0000, 1);
    check("abort_sdo9", SDO, 1'b0);
    check("abort_noerr_yet", ERR_ABORT, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("abort_flag",  ERR_ABORT, 1'b1);
    check("abort_latch", DYNLATCH, DYN_INIT_V);
    check("abort_busy",  BUSY, 1'b0);
    send_dyn_frame(16'hBEEF);
    check("beef_latch", DYNLATCH, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b0);
    check("beef_valid", DYN_VALID, 1'b1);
    CLR_ERR = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    CLR_ERR = 1'b0;
    check("abort_cleared", ERR_ABORT, 1'b0);

    // Select held 20 cycles: overrun, clear racing an event, then clear
    send_dyn_frame(16'hC3A5);
    check("ovr_latch",   DYNLATCH, 16'hC3A5);
    check("ovr_not_yet", ERR_OVR, 1'b0);
    for (int i = 0; i < 3 - FRAME_EXTRA; i++) drive(1'b1, 1'b0, 1'b1);
    check("ovr_flag",     ERR_OVR, 1'b1);
    check("ovr_sdo_hold", SDO, 1'b0);
    CLR_ERR = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    check("ovr_event_wins", ERR_OVR, 1'b1);
    check("ovr_latch_keep", DYNLATCH, 16'hC3A5);
    drive(1'b0, 1'b0, 1'b0);
    CLR_ERR = 1'b0;
    check("ovr_cleared", ERR_OVR, 1'b0);
    check("ovr_busy",    BUSY, 1'b0);

    // Both selects high for 4 cycles
    drive(1'b1, 1'b1, 1'b1);
    check("sel_flag",  ERR_SEL, 1'b1);
    check("sel_busy",  BUSY, 1'b1);
    check("sel_sdo",   SDO, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1);
    check("sel_dyn_keep",  DYNLATCH, 16'hC3A5);
    check("sel_stat_keep", STATLATCH, STAT_PAT);
    check("sel_sdo_end",   SDO, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("sel_busy_end",  BUSY, 1'b0);
    check("sel_valid",     {DYN_VALID, STAT_VALID, ERR_ABORT}, 3'b000);

`ifdef SHIFTREG_PARITY_EN
    // Parity: bad then good for 16'h0001
    send_dyn_bits(16'h0001, 16);
    drive(1'b1, 1'b0, 1'b0);
    check("par_bad_flag",  ERR_PAR, 1'b1);
    check("par_bad_latch", DYNLATCH, 16'hC3A5);
    drive(1'b0, 1'b0, 1'b0);
    check("par_bad_valid", DYN_VALID, 1'b0);
    send_dyn_bits(16'h0001, 16);
    drive(1'b1, 1'b0, 1'b1);
    check("par_good_latch", DYNLATCH, 16'h0001);
    drive(1'b0, 1'b0, 1'b0);
    check("par_good_valid", DYN_VALID, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
